uart_tx_fifo: RTL and testbench

//   Parametrised UART transmitter with TX FIFO: next generation of the fixed 8N1 UART.

---
 rtl/uart_tx_fifo.sv | 112 +++++++++++
 tb/tb_uart_tx_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a byte/word-push TX FIFO, configurable frame
// format and a runtime baud divisor that only changes between frames.
module uart_tx_fifo #(
  parameter int FifoDepth     = 256,
  parameter int DataBits      = 8,
  parameter int WordBytes     = 4,
  parameter int CmpWidth      = 16,
  parameter int DefaultCmpVal = 173,
  parameter int ParityEn      = 0,
  parameter int ParityOdd     = 0,
  parameter int StopBits      = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_byte_en,
  input  logic                         wr_word_en,
  input  logic [8*WordBytes-1:0]       wr_data,
  input  logic                         cmp_load,
  input  logic [CmpWidth-1:0]          cmp_val,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FifoDepth):0]   fifo_count,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic                         overflow
);
  localparam int AW = $clog2(FifoDepth);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, nxt;
  logic [DataBits-1:0] mem [FifoDepth];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, n_push;
  logic [DataBits-1:0] shreg;
  logic par, pend;
  logic [CmpWidth-1:0] div, cnt, pend_val;
  logic [3:0] idx;
  logic bit_end, data_end, stop_end, word_ok, push_w, push_b, pop;
  assign fifo_count = count;
  assign fifo_empty = count == '0;
  assign fifo_full  = count == CW'(FifoDepth);
  // free space is judged on the pre-pop count, so a same-cycle pop never makes room
  assign word_ok  = count <= CW'(FifoDepth - WordBytes);
  assign push_w   = wr_word_en && word_ok;
  assign push_b   = !wr_word_en && wr_byte_en && !fifo_full;
  assign n_push   = push_w ? CW'(WordBytes) : push_b ? CW'(1) : '0;
  assign bit_end  = cnt == div - 1'b1;
  assign data_end = state == DATA && bit_end && idx == 4'(DataBits - 1);
  assign stop_end = state == STOP && bit_end && idx == 4'(StopBits - 1);
  assign pop      = (state == IDLE || stop_end) && !fifo_empty;
  always_ff @(posedge clk)
    if (push_w)
      for (int i = 0; i < WordBytes; i++) mem[wptr + AW'(i)] <= wr_data[8*i +: DataBits];
    else if (push_b)
      mem[wptr] <= wr_data[DataBits-1:0];
  always_ff @(posedge clk)
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wptr     <= wptr + AW'(n_push);
      rptr     <= rptr + AW'(pop);
      count    <= count + n_push - CW'(pop);
      overflow <= (wr_word_en && !word_ok) || (!wr_word_en && wr_byte_en && fifo_full);
    end
  // a divisor load waits as pending until the line is idle so frames keep one rate
  always_ff @(posedge clk)
    if (reset) begin
      div      <= CmpWidth'(DefaultCmpVal);
      pend     <= 1'b0;
      pend_val <= '0;
    end else begin
      if (state == IDLE && pend) div <= pend_val;
      if (cmp_load) begin
        pend     <= 1'b1;
        pend_val <= cmp_val < 2 ? CmpWidth'(2) : cmp_val;
      end else if (state == IDLE) pend <= 1'b0;
    end
  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = fifo_empty ? IDLE : START;
      START:   nxt = bit_end ? DATA : START;
      DATA:    nxt = data_end ? (ParityEn != 0 ? PARITY : STOP) : DATA;
      PARITY:  nxt = bit_end ? STOP : PARITY;
      STOP:    nxt = stop_end ? (fifo_empty ? IDLE : START) : STOP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      par   <= 1'b0;
    end else begin
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      idx <= state != nxt ? '0 : (bit_end && (state == DATA || state == STOP)) ? idx + 1'b1 : idx;
      if (pop) begin
        shreg <= mem[rptr];
        par   <= ^mem[rptr] ^ 1'(ParityOdd);
      end else if (state == DATA && bit_end) shreg <= shreg >> 1;
    end
  always_comb begin
    tx   = state == START ? 1'b0 : state == DATA ? shreg[0] : state == PARITY ? par : 1'b1;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of uart_tx_fifo against a
// frame-level model (expected bit list held for divisor cycles per bit).
module tb_uart_tx_fifo;
  logic clk = 1'b0, reset = 1'b1, wr_byte_en = 1'b0, wr_word_en = 1'b0, cmp_load = 1'b0;
  logic [31:0] wr_data = '0;
  logic [15:0] cmp_val = '0;
  logic tx, busy, fifo_full, fifo_empty, overflow;
  logic [8:0] fifo_count;
  logic tx1, busy1, full1, empty1, ovf1, tx2, busy2, full2, empty2, ovf2;
  logic [8:0] cnt1, cnt2;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  uart_tx_fifo dut (.clk(clk), .reset(reset), .wr_byte_en(wr_byte_en), .wr_word_en(wr_word_en),
    .wr_data(wr_data), .cmp_load(cmp_load), .cmp_val(cmp_val), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow));
  uart_tx_fifo #(.ParityEn(1), .ParityOdd(0)) dut_even (.clk(clk), .reset(reset),
    .wr_byte_en(wr_byte_en), .wr_word_en(wr_word_en), .wr_data(wr_data), .cmp_load(cmp_load),
    .cmp_val(cmp_val), .tx(tx1), .busy(busy1), .fifo_count(cnt1), .fifo_full(full1),
    .fifo_empty(empty1), .overflow(ovf1));
  uart_tx_fifo #(.ParityEn(1), .ParityOdd(1)) dut_odd (.clk(clk), .reset(reset),
    .wr_byte_en(wr_byte_en), .wr_word_en(wr_word_en), .wr_data(wr_data), .cmp_load(cmp_load),
    .cmp_val(cmp_val), .tx(tx2), .busy(busy2), .fifo_count(cnt2), .fifo_full(full2),
    .fifo_empty(empty2), .overflow(ovf2));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic tx_of(input int sel);
    return sel == 0 ? tx : sel == 1 ? tx1 : tx2;
  endfunction
  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic load(input int v);
    cmp_load = 1'b1;
    cmp_val  = 16'(v);
    tick();
    cmp_load = 1'b0;
    tick();
  endtask
  task automatic push_byte(input logic [7:0] b);
    wr_data    = {24'h0, b};
    wr_byte_en = 1'b1;
    tick();
    wr_byte_en = 1'b0;
  endtask
  task automatic push_word(input logic [31:0] w);
    wr_data    = w;
    wr_word_en = 1'b1;
    tick();
    wr_word_en = 1'b0;
  endtask
  // waits up to maxw cycles for the start bit, then checks every cycle of the frame
  task automatic frame(input int sel, input logic [7:0] b, input int div, input int maxw,
                       input int ld_at, input int ld_val, input int exp_cnt);
    int w, nb, k;
    logic par_en, odd, e;
    par_en = sel != 0;
    odd    = sel == 2;
    w = 0;
    while (tx_of(sel) !== 1'b0 && w < maxw) begin
      tick();
      w++;
    end
    chk($sformatf("start_seen_%0d", sel), 32'(tx_of(sel)), 32'h0);
    if (exp_cnt >= 0) chk("count_at_start", 32'(fifo_count), 32'(exp_cnt));
    nb = par_en ? 11 : 10;
    for (int c = 0; c < nb * div; c++) begin
      k = c / div;
      e = k == 0 ? 1'b0 : k <= 8 ? b[k-1] : (par_en && k == 9) ? (^b ^ odd) : 1'b1;
      chk($sformatf("tx%0d_bit%0d_cyc%0d", sel, k, c), 32'(tx_of(sel)), 32'(e));
      if (sel == 0) chk("busy_in_frame", 32'(busy), 32'h1);
      cmp_load = c == ld_at;
      cmp_val  = 16'(ld_val);
      tick();
    end
    cmp_load = 1'b0;
  endtask
  initial begin
    int v, d, n;
    logic [31:0] w;
    logic [7:0] q[$];
    tick();
    reset = 1'b0;
    chk("rst_tx", 32'(tx), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_empty", 32'(fifo_empty), 32'h1);
    chk("rst_full", 32'(fifo_full), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    // single byte at divisor 4, two-cycle push-to-start latency
    load(4);
    push_byte(8'hA5);
    chk("latency_tx_still_high", 32'(tx), 32'h1);
    tick();
    frame(0, 8'hA5, 4, 0, -1, 0, 0);
    chk("t1_busy_done", 32'(busy), 32'h0);
    chk("t1_tx_idle", 32'(tx), 32'h1);
    // word push wins over byte push; four frames back to back
    wr_data    = 32'h44332211;
    wr_word_en = 1'b1;
    wr_byte_en = 1'b1;
    tick();
    wr_word_en = 1'b0;
    wr_byte_en = 1'b0;
    chk("t2_count_after_word", 32'(fifo_count), 32'h4);
    chk("t2_no_ovf", 32'(overflow), 32'h0);
    tick();
    frame(0, 8'h11, 4, 0, -1, 0, 3);
    frame(0, 8'h22, 4, 0, -1, 0, 2);
    frame(0, 8'h33, 4, 0, -1, 0, 1);
    frame(0, 8'h44, 4, 0, -1, 0, 0);
    chk("t2_busy_done", 32'(busy), 32'h0);
    // fill to 254 behind a slow frame, then probe the full boundary
    load(1000);
    push_byte(8'h00);
    for (int i = 0; i < 63; i++) push_word($urandom);
    push_byte(8'h01);
    push_byte(8'h02);
    chk("t3_count_254", 32'(fifo_count), 32'd254);
    push_word(32'hDEADBEEF);
    chk("t3_word_ovf", 32'(overflow), 32'h1);
    chk("t3_word_rejected", 32'(fifo_count), 32'd254);
    tick();
    chk("t3_ovf_pulse_end", 32'(overflow), 32'h0);
    push_byte(8'h03);
    chk("t3_count_255", 32'(fifo_count), 32'd255);
    chk("t3_not_full", 32'(fifo_full), 32'h0);
    push_byte(8'h04);
    chk("t3_count_256", 32'(fifo_count), 32'd256);
    chk("t3_full", 32'(fifo_full), 32'h1);
    push_byte(8'h05);
    chk("t3_byte_ovf", 32'(overflow), 32'h1);
    chk("t3_count_held", 32'(fifo_count), 32'd256);
    do_reset();
    chk("t3_rst_count", 32'(fifo_count), 32'h0);
    chk("t3_rst_tx", 32'(tx), 32'h1);
    // divisor change mid-frame takes effect only for the next frame
    load(4);
    push_byte(8'h5A);
    tick();
    frame(0, 8'h5A, 4, 0, 13, 8, 0);
    chk("t4_busy_done", 32'(busy), 32'h0);
    push_byte(8'hC3);
    tick();
    frame(0, 8'hC3, 8, 0, -1, 0, 0);
    // parity variants
    do_reset();
    load(4);
    push_byte(8'h07);
    tick();
    frame(1, 8'h07, 4, 0, -1, 0, -1);
    do_reset();
    load(4);
    push_byte(8'h07);
    tick();
    frame(2, 8'h07, 4, 0, -1, 0, -1);
    // reset in the middle of DATA
    do_reset();
    load(4);
    push_byte(8'h96);
    push_byte(8'h69);
    chk("t6_started", 32'(tx), 32'h0);
    repeat (10) tick();
    chk("t6_busy_before", 32'(busy), 32'h1);
    do_reset();
    chk("t6_tx", 32'(tx), 32'h1);
    chk("t6_count", 32'(fifo_count), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    push_byte(8'h3C);
    tick();
    frame(0, 8'h3C, 173, 0, -1, 0, 0);
    // randomized rounds: two pushes, the second coinciding with the first pop
    for (int r = 0; r < 6; r++) begin
      v = r == 0 ? 1 : int'($urandom_range(0, 5));
      d = v < 2 ? 2 : v;
      load(v);
      for (int p = 0; p < 2; p++) begin
        w = $urandom;
        wr_data = w;
        if ($urandom_range(0, 1) == 1) begin
          wr_word_en = 1'b1;
          for (int j = 0; j < 4; j++) q.push_back(w[8*j +: 8]);
        end else begin
          wr_byte_en = 1'b1;
          q.push_back(w[7:0]);
        end
        tick();
        wr_word_en = 1'b0;
        wr_byte_en = 1'b0;
      end
      n = q.size();
      for (int i = 0; i < n; i++) frame(0, q[i], d, 0, -1, 0, n - 1 - i);
      chk("rnd_busy_done", 32'(busy), 32'h0);
      q.delete();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
